// File: rtl/isp_pkg.sv
// Shared definitions for the ISP UART-to-RAM loader.
// Holds the FSM state encoding, a constant clog2 helper and the default frame timeout.
package isp_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RECV  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int TIMEOUT_CYC_DEF = 50000;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/uart_ram_lane_pack.sv
// Byte-lane assembler: each wr_i stores one byte in the next lane; word_o/be_o already include
// the byte written this cycle, full_o flags the word-completing byte. No backpressure.
module uart_ram_lane_pack
    import isp_pkg::*;
#(
    parameter int WORD_BYTES = 4,
    parameter bit BIG_ENDIAN = 1'b0,
    localparam int LANE_W    = (clog2(WORD_BYTES) < 1) ? 1 : clog2(WORD_BYTES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_i,
    input  logic                    clr_i,
    input  logic [7:0]              dat_i,
    output logic [8*WORD_BYTES-1:0] word_o,
    output logic [WORD_BYTES-1:0]   be_o,
    output logic                    full_o,
    output logic                    empty_o
);

    logic [LANE_W-1:0]       lane_q, lane_d;
    logic [8*WORD_BYTES-1:0] store_q, store_d;
    int                      fill;

    function automatic int phys(input int idx);
        return BIG_ENDIAN ? (WORD_BYTES - 1 - idx) : idx;
    endfunction

    assign full_o  = wr_i & (lane_q == LANE_W'(WORD_BYTES - 1));
    assign empty_o = (lane_q == '0);
    assign word_o  = store_d;

    always_comb begin
        store_d = store_q;
        if (wr_i) begin
            // A new word starts clean so unfilled lanes of a later flush read as zero.
            if (lane_q == '0) store_d = '0;
            store_d[8*phys(int'(lane_q)) +: 8] = dat_i;
        end
    end

    always_comb begin
        fill = int'(lane_q) + (wr_i ? 1 : 0);
        be_o = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (i < fill) be_o[phys(i)] = 1'b1;
        end
    end

    always_comb begin
        lane_d = lane_q;
        if (clr_i || full_o) lane_d = '0;
        else if (wr_i)       lane_d = lane_q + LANE_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q  <= '0;
            store_q <= '0;
        end else begin
            lane_q  <= lane_d;
            store_q <= store_d;
        end
    end

endmodule

// File: rtl/uart_ram_loader.sv
// UART byte stream to RAM word writer with idle-timeout framing and partial-word flush; a write
// follows its completing byte by one cycle, no backpressure. Optional checksum: UART_RAM_LOADER_CHECKSUM_EN.
module uart_ram_loader
    import isp_pkg::*;
#(
    parameter int WORD_BYTES  = 4,
    parameter int ADDR_W      = 16,
    parameter int BASE_ADDR   = 0,
    parameter bit BIG_ENDIAN  = 1'b0,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rx_data,
    input  logic                    rx_flag,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [8*WORD_BYTES-1:0] wr_data,
    output logic [WORD_BYTES-1:0]   wr_be,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [7:0]              checksum
);

    localparam int                TMR_W = clog2(TIMEOUT_CYC);
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

    logic [1:0]              state_q, state_d;
    logic                    rx_flag_q;
    logic                    pend_q, pend_d;
    logic [7:0]              pend_dat_q, pend_dat_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic [ADDR_W-1:0]       addr_q, addr_d, addr_cur;
    logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
    logic                    wr_en_q, wr_en_d;
    logic [8*WORD_BYTES-1:0] wr_data_q, wr_data_d;
    logic [WORD_BYTES-1:0]   wr_be_q, wr_be_d;
    logic                    ovf_q, ovf_d;
    logic                    byte_ev, accept, frame_start, lane_clr;
    logic [7:0]              ev_dat;
    logic [8*WORD_BYTES-1:0] pk_word;
    logic [WORD_BYTES-1:0]   pk_be;
    logic                    pk_full, pk_empty;

    assign byte_ev     = rx_flag & ~rx_flag_q;
    // A byte held over from FLUSH/DONE goes first; a colliding fresh byte takes its slot.
    assign ev_dat      = pend_q ? pend_dat_q : rx_data;
    assign accept      = (byte_ev | pend_q) & ((state_q == ST_IDLE) | (state_q == ST_RECV));
    assign frame_start = accept & (state_q == ST_IDLE);
    assign addr_cur    = frame_start ? BASE : addr_q;

    uart_ram_lane_pack #(
        .WORD_BYTES (WORD_BYTES),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_pack (
        .clk     (clk),
        .rst     (rst),
        .wr_i    (accept),
        .clr_i   (lane_clr),
        .dat_i   (ev_dat),
        .word_o  (pk_word),
        .be_o    (pk_be),
        .full_o  (pk_full),
        .empty_o (pk_empty)
    );

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pend_dat_d = pend_dat_q;
        timer_d    = timer_q;
        addr_d     = addr_q;
        wr_addr_d  = wr_addr_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        wr_be_d    = wr_be_q;
        ovf_d      = ovf_q;
        lane_clr   = 1'b0;
        if (accept) begin
            state_d    = ST_RECV;
            pend_d     = pend_q & byte_ev;
            pend_dat_d = rx_data;
            timer_d    = '0;
            addr_d     = addr_cur;
            if (frame_start) ovf_d = 1'b0;
            if (pk_full) begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_cur;
                wr_data_d = pk_word;
                wr_be_d   = pk_be;
                addr_d    = addr_cur + ADDR_W'(1);
                if (addr_cur == '1) ovf_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_RECV: begin
                    if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                        timer_d = '0;
                        if (!pk_empty) begin
                            state_d   = ST_FLUSH;
                            wr_en_d   = 1'b1;
                            wr_addr_d = addr_q;
                            wr_data_d = pk_word;
                            wr_be_d   = pk_be;
                            lane_clr  = 1'b1;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                ST_FLUSH: state_d = ST_DONE;
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
            if (byte_ev) begin
                pend_d     = 1'b1;
                pend_dat_d = rx_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rx_flag_q  <= 1'b0;
            pend_q     <= 1'b0;
            pend_dat_q <= '0;
            timer_q    <= '0;
            addr_q     <= BASE;
            wr_addr_q  <= BASE;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            wr_be_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_flag_q  <= rx_flag;
            pend_q     <= pend_d;
            pend_dat_q <= pend_dat_d;
            timer_q    <= timer_d;
            addr_q     <= addr_d;
            wr_addr_q  <= wr_addr_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            wr_be_q    <= wr_be_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef UART_RAM_LOADER_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;

    assign sum_d = (frame_start ? 8'd0 : sum_q) + ev_dat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         sum_q <= '0;
        else if (accept) sum_q <= sum_d;
    end

    assign checksum = sum_q;
`else
    assign checksum = 8'd0;
`endif

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign wr_be    = wr_be_q;
    assign busy     = (state_q == ST_RECV) | (state_q == ST_FLUSH);
    assign done     = (state_q == ST_DONE);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_ram_loader.sv
// Three loaders (little-endian, big-endian, 2-bit address) share one byte stream; a frame-level
// model predicts every write, done, busy and overflow cycle from the byte arrival times.
module tb_uart_ram_loader;

    localparam int T  = 8;
    localparam int NC = 1024;
    localparam int NI = 3;

    typedef struct {
        bit        wr;
        bit [15:0] addr;
        bit [31:0] data;
        bit [3:0]  be;
        bit        done;
        bit        busy;
        bit        ovf;
        bit [7:0]  sum;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [7:0]           rx_data = 8'd0;
    logic                 rx_flag = 1'b0;
    logic [NI-1:0]        w_en, o_busy, o_done, o_ovf;
    logic [NI-1:0][15:0]  w_addr;
    logic [NI-1:0][31:0]  w_data;
    logic [NI-1:0][3:0]   w_be;
    logic [NI-1:0][7:0]   o_sum;
    logic [15:0]          addr_le, addr_be;
    logic [1:0]           addr2;

    exp_t       ex [NI][NC];
    exp_t       zero_e;
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    bit         chk_en = 1'b0;
    int         done_cnt [NI];
    int         ev_off [$];
    logic [7:0] ev_val [$];
    int         ev_cyc [64];

    uart_ram_loader #(.TIMEOUT_CYC(T)) u_le (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_flag(rx_flag),
        .wr_en(w_en[0]), .wr_addr(addr_le), .wr_data(w_data[0]), .wr_be(w_be[0]),
        .busy(o_busy[0]), .done(o_done[0]), .overflow(o_ovf[0]), .checksum(o_sum[0]));

    uart_ram_loader #(.TIMEOUT_CYC(T), .BIG_ENDIAN(1'b1)) u_be (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_flag(rx_flag),
        .wr_en(w_en[1]), .wr_addr(addr_be), .wr_data(w_data[1]), .wr_be(w_be[1]),
        .busy(o_busy[1]), .done(o_done[1]), .overflow(o_ovf[1]), .checksum(o_sum[1]));

    uart_ram_loader #(.TIMEOUT_CYC(T), .ADDR_W(2)) u_wrap (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_flag(rx_flag),
        .wr_en(w_en[2]), .wr_addr(addr2), .wr_data(w_data[2]), .wr_be(w_be[2]),
        .busy(o_busy[2]), .done(o_done[2]), .overflow(o_ovf[2]), .checksum(o_sum[2]));

    assign w_addr[0] = addr_le;
    assign w_addr[1] = addr_be;
    assign w_addr[2] = {14'd0, addr2};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", name, inst, cyc, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst && cyc < NC) begin
            for (int i = 0; i < NI; i++) begin
                exp_t e;
                e = ex[i][cyc];
                chk("wr_en", i, 32'(w_en[i]), 32'(e.wr));
                chk("done", i, 32'(o_done[i]), 32'(e.done));
                chk("busy", i, 32'(o_busy[i]), 32'(e.busy));
                chk("overflow", i, 32'(o_ovf[i]), 32'(e.ovf));
                if (e.wr) begin
                    chk("wr_addr", i, 32'(w_addr[i]), 32'(e.addr));
                    chk("wr_data", i, w_data[i], e.data);
                    chk("wr_be", i, 32'(w_be[i]), 32'(e.be));
                end
                if (e.done) begin
`ifdef UART_RAM_LOADER_CHECKSUM_EN
                    chk("checksum", i, 32'(o_sum[i]), 32'(e.sum));
`else
                    chk("checksum", i, 32'(o_sum[i]), 32'd0);
`endif
                end
                if (o_done[i]) done_cnt[i]++;
            end
        end
    end

    task automatic fill_lvl(input int i, input int from, input int to_excl, input bit is_ovf, input bit v);
        for (int c = from; c < to_excl && c < NC; c++) begin
            if (is_ovf) ex[i][c].ovf = v;
            else        ex[i][c].busy = v;
        end
    endtask

    // Frame-level model: bytes within T cycles of the previous accepted byte join the frame.
    task automatic model(input int i, input bit big, input int aw, input int n, input int end_c);
        int         a, a0, last_a, idle_from, nfill, addr, lb, pos;
        bit         in_frame;
        logic [31:0] word;
        logic [3:0]  be;
        logic [7:0]  sum;
        in_frame = 0; idle_from = 0; last_a = 0; a0 = 0; nfill = 0; addr = 0;
        word = '0; be = '0; sum = '0;
        for (int k = 0; k <= n; k++) begin
            if (in_frame && (k == n || ev_cyc[k] - last_a > T)) begin
                lb = last_a + T + ((nfill > 0) ? 1 : 0);
                if (nfill > 0 && lb < end_c) begin
                    ex[i][lb].wr = 1; ex[i][lb].addr = 16'(addr);
                    ex[i][lb].data = word; ex[i][lb].be = be;
                end
                fill_lvl(i, a0 + 1, (lb + 1 < end_c) ? lb + 1 : end_c, 0, 1);
                if (lb + 1 < end_c) begin
                    ex[i][lb + 1].done = 1; ex[i][lb + 1].sum = sum;
                end
                idle_from = lb + 2;
                in_frame = 0; nfill = 0; word = '0; be = '0;
            end
            if (k < n) begin
                if (!in_frame) begin
                    a = (ev_cyc[k] > idle_from) ? ev_cyc[k] : idle_from;
                    a0 = a; in_frame = 1; addr = 0; sum = '0;
                    fill_lvl(i, a + 1, end_c, 1, 0);
                end else begin
                    a = (ev_cyc[k] > last_a + 1) ? ev_cyc[k] : last_a + 1;
                end
                pos = big ? 3 - nfill : nfill;
                word[pos*8 +: 8] = ev_val[k];
                be[pos] = 1'b1;
                nfill++;
                sum = sum + ev_val[k];
                if (nfill == 4) begin
                    if (a + 1 < end_c) begin
                        ex[i][a + 1].wr = 1; ex[i][a + 1].addr = 16'(addr);
                        ex[i][a + 1].data = word; ex[i][a + 1].be = be;
                    end
                    addr = (addr + 1) % (1 << aw);
                    if (addr == 0) fill_lvl(i, a + 1, end_c, 1, 1);
                    nfill = 0; word = '0; be = '0;
                end
                last_a = a;
            end
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int i = 0; i < NI; i++) begin
            chk({tag, "_wr_en"}, i, 32'(w_en[i]), 32'd0);
            chk({tag, "_wr_addr"}, i, 32'(w_addr[i]), 32'd0);
            chk({tag, "_wr_data"}, i, w_data[i], 32'd0);
            chk({tag, "_wr_be"}, i, 32'(w_be[i]), 32'd0);
            chk({tag, "_busy"}, i, 32'(o_busy[i]), 32'd0);
            chk({tag, "_done"}, i, 32'(o_done[i]), 32'd0);
            chk({tag, "_overflow"}, i, 32'(o_ovf[i]), 32'd0);
            chk({tag, "_checksum"}, i, 32'(o_sum[i]), 32'd0);
        end
    endtask

    task automatic add(input int off, input logic [7:0] val);
        ev_off.push_back(off);
        ev_val.push_back(val);
    endtask

    task automatic prep(input int len, output int base);
        chk_en = 1'b0;
        rx_flag = 1'b0;
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        base = cyc;
        for (int i = 0; i < NI; i++)
            for (int c = base; c < base + len + 2 && c < NC; c++) ex[i][c] = zero_e;
        for (int k = 0; k < ev_off.size(); k++) ev_cyc[k] = base + ev_off[k];
        model(0, 1'b0, 16, ev_off.size(), base + len);
        model(1, 1'b1, 16, ev_off.size(), base + len);
        model(2, 1'b0, 2,  ev_off.size(), base + len);
        chk_en = 1'b1;
    endtask

    task automatic drive(input int len);
        for (int o = 0; o < len; o++) begin
            rx_flag = 1'b0;
            for (int k = 0; k < ev_off.size(); k++) begin
                if (ev_off[k] == o) begin
                    rx_flag = 1'b1;
                    rx_data = ev_val[k];
                end
            end
            @(posedge clk); #1;
        end
        rx_flag = 1'b0;
        chk_en = 1'b0;
        ev_off.delete();
        ev_val.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b, d0;
        for (int i = 0; i < NI; i++) done_cnt[i] = 0;
        #2;
        chk_reset_vals("rst_init");

        // Two full words.
        for (int k = 0; k < 8; k++) add(2 + 2*k, 8'(8'h11 * (k + 1)));
        prep(30, b);
        chk("pinA_data0", 0, ex[0][b+9].data, 32'h44332211);
        chk("pinA_be0", 0, 32'(ex[0][b+9].be), 32'hF);
        chk("pinA_addr1", 0, 32'(ex[0][b+17].addr), 32'd1);
        chk("pinA_data1", 0, ex[0][b+17].data, 32'h88776655);
        chk("pinA_done", 0, 32'(ex[0][b+25].done), 32'd1);
        chk("pinA_big", 1, ex[1][b+9].data, 32'h11223344);
        drive(30);

        // Partial flush.
        add(2, 8'hAA); add(4, 8'hBB); add(6, 8'hCC);
        prep(20, b);
        chk("pinB_data", 1, ex[1][b+15].data, 32'hAABBCC00);
        chk("pinB_be", 1, 32'(ex[1][b+15].be), 32'hE);
        chk("pinB_done", 1, 32'(ex[1][b+16].done), 32'd1);
        chk("pinB_le", 0, ex[0][b+15].data, 32'h00CCBBAA);
        drive(20);

        // Byte exactly on the timer-expiry cycle.
        add(2, 8'h01); add(4, 8'h02); add(12, 8'h03); add(20, 8'h04);
        prep(34, b);
        chk("pinC_noflush", 0, 32'(ex[0][b+13].wr), 32'd0);
        chk("pinC_data", 0, ex[0][b+21].data, 32'h04030201);
        d0 = done_cnt[0];
        drive(34);
        chk("race_done_count", 0, 32'(done_cnt[0] - d0), 32'd1);

        // Address wrap, then a new frame whose first byte lands in DONE.
        for (int k = 0; k < 20; k++) add(2 + 2*k, 8'(k + 1));
        add(49, 8'hE1); add(51, 8'hE2); add(53, 8'hE3); add(55, 8'hE4);
        prep(69, b);
        chk("pinD_a3", 2, 32'(ex[2][b+33].addr), 32'd3);
        chk("pinD_wrap", 2, 32'(ex[2][b+41].addr), 32'd0);
        chk("pinD_ovf", 2, 32'(ex[2][b+45].ovf), 32'd1);
        chk("pinD_new_addr", 2, 32'(ex[2][b+56].addr), 32'd0);
        chk("pinD_new_ovf", 2, 32'(ex[2][b+52].ovf), 32'd0);
        chk("pinD_le_addr", 0, 32'(ex[0][b+41].addr), 32'd4);
        drive(69);

        // Reset mid-frame after two bytes.
        add(2, 8'h11); add(4, 8'h22);
        prep(7, b);
        drive(7);
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_mid");

        // Fresh frame after that reset starts at the base address.
        add(2, 8'h5A); add(4, 8'hA5); add(6, 8'hC3); add(8, 8'h3C);
        prep(22, b);
        chk("pinF_addr", 0, 32'(ex[0][b+9].addr), 32'd0);
        chk("pinF_data", 0, ex[0][b+9].data, 32'h3CC3A55A);
        drive(22);

        // Checksum of a flushed FF,02 frame.
        add(2, 8'hFF); add(4, 8'h02);
        prep(18, b);
        chk("pinG_sum", 0, 32'(ex[0][b+14].sum), 32'h01);
        chk("pinG_data", 0, ex[0][b+13].data, 32'h000002FF);
        chk("pinG_be", 0, 32'(ex[0][b+13].be), 32'h3);
        drive(18);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
